// File: rtl/selectio_wiz_pkg.sv
// -----------------------------------------------------------------------------
// selectio_wiz_pkg
// Shared constants for the source-synchronous DDR ADC front end.
//   SYS_W        number of differential lanes (lane 0 = over-range, 1..12 = ADC)
//   DEV_W        width of the captured word presented downstream (2*SYS_W)
//   TAP_W        width of the per-lane tap delay
//   LOCK_CYCLES  rising edges from reset release until delay_locked
//   HIST_DEPTH   half-cycle samples of history kept per lane
//   OVR_LANE     lane index carrying the ADC over-range line
//   LOCK_W       width of the lock counter
// -----------------------------------------------------------------------------
package selectio_wiz_pkg;
  localparam int SYS_W       = 13;
  localparam int DEV_W       = 2 * SYS_W;
  localparam int TAP_W       = 5;
  localparam int LOCK_CYCLES = 32;
  localparam int HIST_DEPTH  = 34;
  localparam int OVR_LANE    = 0;
  localparam int LOCK_W      = $clog2(LOCK_CYCLES + 1);
endpackage : selectio_wiz_pkg

// File: rtl/selectio_wiz_if.sv
// -----------------------------------------------------------------------------
// selectio_wiz_if
// Bundles the pin, tap-control and captured-data signals of selectio_wiz.
//   master : drives pins and tap controls, observes captured data/taps/lock
//   slave  : the front end itself
// -----------------------------------------------------------------------------
interface selectio_wiz_if;
  import selectio_wiz_pkg::*;

  logic [SYS_W-1:0]       data_in_from_pins_p;
  logic [SYS_W-1:0]       data_in_from_pins_n;
  logic                   in_delay_reset;
  logic [SYS_W*TAP_W-1:0] in_delay_tap_in;
  logic [SYS_W-1:0]       in_delay_data_ce;
  logic [SYS_W-1:0]       in_delay_data_inc;
  logic [SYS_W*TAP_W-1:0] in_delay_tap_out;
  logic [DEV_W-1:0]       data_in_to_device;
  logic                   delay_locked;

  modport master (
    output data_in_from_pins_p, data_in_from_pins_n,
    output in_delay_reset, in_delay_tap_in, in_delay_data_ce, in_delay_data_inc,
    input  in_delay_tap_out, data_in_to_device, delay_locked
  );

  modport slave (
    input  data_in_from_pins_p, data_in_from_pins_n,
    input  in_delay_reset, in_delay_tap_in, in_delay_data_ce, in_delay_data_inc,
    output in_delay_tap_out, data_in_to_device, delay_locked
  );
endinterface : selectio_wiz_if

// File: rtl/selectio_wiz_lane.sv
// -----------------------------------------------------------------------------
// selectio_lane
// One differential lane: receiver, rise/fall capture, tap register,
// half-cycle history and tap-selected DDR output register.
//   clk_i, rst_ni         capture clock (both edges) and async active-low reset
//   pin_p_i, pin_n_i      differential pair
//   tap_load_i, tap_in_i  load tap value (highest priority)
//   tap_ce_i, tap_inc_i   step tap up/down with wrap
//   tap_o                 current tap
//   rise_o, fall_o        registered delayed rise/fall sample pair
// -----------------------------------------------------------------------------
module selectio_lane
  import selectio_wiz_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             pin_p_i,
  input  logic             pin_n_i,
  input  logic             tap_load_i,
  input  logic [TAP_W-1:0] tap_in_i,
  input  logic             tap_ce_i,
  input  logic             tap_inc_i,
  output logic [TAP_W-1:0] tap_o,
  output logic             rise_o,
  output logic             fall_o
);
  logic                  rx_bit;
  logic                  rise_cap_q;
  logic                  fall_cap_q;
  logic [HIST_DEPTH-1:0] hist_q;
  logic [HIST_DEPTH-1:0] hist_d;
  logic [TAP_W-1:0]      tap_q;
  logic [TAP_W-1:0]      tap_d;
  logic [TAP_W:0]        sel_fall;
  logic [TAP_W:0]        sel_rise;
  logic                  rise_q;
  logic                  rise_d;
  logic                  fall_q;
  logic                  fall_d;
  logic                  unused_hist;

  // An equal pair is either undriven or invalid; treat it as 0.
  assign rx_bit = (pin_p_i != pin_n_i) ? pin_p_i : 1'b0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rise_cap_q <= 1'b0;
    else         rise_cap_q <= rx_bit;
  end

  always_ff @(negedge clk_i or negedge rst_ni) begin
    if (!rst_ni) fall_cap_q <= 1'b0;
    else         fall_cap_q <= rx_bit;
  end

  // Newest-first half-cycle stream as seen at this rising edge:
  //   [0] = fall sample of the previous cycle, [1] = its rise sample,
  //   [j+2] = older history. Tap t then reads fall=[t], rise=[t+1].
  assign hist_d = {hist_q[HIST_DEPTH-3:0], rise_cap_q, fall_cap_q};

  // The two oldest entries are never reachable by a 5-bit tap.
  assign unused_hist = ^hist_q[HIST_DEPTH-1:HIST_DEPTH-2];

  assign sel_fall = {1'b0, tap_q};
  assign sel_rise = sel_fall + (TAP_W+1)'(1);
  assign fall_d   = hist_d[sel_fall];
  assign rise_d   = hist_d[sel_rise];

  always_comb begin
    tap_d = tap_q;
    if (tap_load_i)                  tap_d = tap_in_i;
    else if (tap_ce_i && tap_inc_i)  tap_d = tap_q + TAP_W'(1);
    else if (tap_ce_i)               tap_d = tap_q - TAP_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hist_q <= '0;
      tap_q  <= '0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      hist_q <= hist_d;
      tap_q  <= tap_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign tap_o  = tap_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;
endmodule : selectio_lane

// File: rtl/selectio_wiz.sv
// -----------------------------------------------------------------------------
// selectio_wiz
// Vendor-neutral DDR input front end for the 12-bit ADC plus over-range line.
//   clk_in      ADC clock, both edges used
//   io_reset_n  asynchronous active-low reset
//   bus         selectio_wiz_if.slave: pins, tap control, captured word,
//               tap readback, delay_locked
// Output word: [i] = rise sample of lane i, [i+SYS_W] = fall sample.
// -----------------------------------------------------------------------------
module selectio_wiz
  import selectio_wiz_pkg::*;
(
  input  logic          clk_in,
  input  logic          io_reset_n,
  selectio_wiz_if.slave bus
);
  logic [SYS_W-1:0]  lane_rise;
  logic [SYS_W-1:0]  lane_fall;
  logic [LOCK_W-1:0] cnt_q;
  logic [LOCK_W-1:0] cnt_d;
  logic              locked_q;
  logic              locked_d;

  generate
    for (genvar gi = 0; gi < SYS_W; gi++) begin : g_lane
      selectio_lane u_lane (
        .clk_i      (clk_in),
        .rst_ni     (io_reset_n),
        .pin_p_i    (bus.data_in_from_pins_p[gi]),
        .pin_n_i    (bus.data_in_from_pins_n[gi]),
        .tap_load_i (bus.in_delay_reset),
        .tap_in_i   (bus.in_delay_tap_in[gi*TAP_W +: TAP_W]),
        .tap_ce_i   (bus.in_delay_data_ce[gi]),
        .tap_inc_i  (bus.in_delay_data_inc[gi]),
        .tap_o      (bus.in_delay_tap_out[gi*TAP_W +: TAP_W]),
        .rise_o     (lane_rise[gi]),
        .fall_o     (lane_fall[gi])
      );
    end
  endgenerate

  assign bus.data_in_to_device = {lane_fall, lane_rise};

  // Lock counter: counts edges since reset release and freezes once locked.
  always_comb begin
    cnt_d    = cnt_q;
    locked_d = locked_q;
    if (!locked_q) begin
      cnt_d = cnt_q + LOCK_W'(1);
      if (cnt_q == LOCK_W'(LOCK_CYCLES - 1)) locked_d = 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge io_reset_n) begin
    if (!io_reset_n) begin
      cnt_q    <= '0;
      locked_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      locked_q <= locked_d;
    end
  end

  assign bus.delay_locked = locked_q;
endmodule : selectio_wiz

// File: tb/tb_selectio_wiz.sv
// -----------------------------------------------------------------------------
// tb_selectio_wiz
// Directed self-checking bench for selectio_wiz. Inputs change 1 ns after
// each clock edge; outputs are sampled 1 ns after the falling edge.
// -----------------------------------------------------------------------------
module tb_selectio_wiz;
  import selectio_wiz_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  selectio_wiz_if bus ();

  selectio_wiz dut (
    .clk_in     (clk),
    .io_reset_n (rst_n),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("check %-14s observed %h expected %h", tag, obs, exp);
  endtask

  // One clock cycle: rise values sampled at posedge, fall values at negedge.
  task automatic drive_cycle(input logic [SYS_W-1:0] rp, input logic [SYS_W-1:0] rn,
                             input logic [SYS_W-1:0] fp, input logic [SYS_W-1:0] fn);
    bus.data_in_from_pins_p = rp;
    bus.data_in_from_pins_n = rn;
    @(posedge clk);
    #1;
    bus.data_in_from_pins_p = fp;
    bus.data_in_from_pins_n = fn;
    @(negedge clk);
    #1;
  endtask

  task automatic zero_cycles(input int n);
    for (int i = 0; i < n; i++) drive_cycle('0, '0, '0, '0);
  endtask

  // Starts right after reset release; locked must rise on the 32nd edge.
  task automatic lock_run(input string tag);
    for (int i = 1; i <= LOCK_CYCLES; i++) begin
      @(posedge clk);
      #1;
      check(tag, 65'(bus.delay_locked), 65'(i == LOCK_CYCLES));
    end
    @(negedge clk);
    #1;
  endtask

  function automatic logic [SYS_W*TAP_W-1:0] fill_taps(input logic [TAP_W-1:0] v);
    logic [SYS_W*TAP_W-1:0] r;
    for (int i = 0; i < SYS_W; i++) r[i*TAP_W +: TAP_W] = v;
    return r;
  endfunction

  localparam logic [SYS_W-1:0] L5  = 13'h0020;
  localparam logic [SYS_W-1:0] L0  = 13'h0001;
  localparam logic [SYS_W-1:0] L12 = 13'h1000;

  logic [SYS_W*TAP_W-1:0] taps;

  initial begin
    rst_n                   = 1'b0;
    bus.data_in_from_pins_p = '0;
    bus.data_in_from_pins_n = '0;
    bus.in_delay_reset      = 1'b0;
    bus.in_delay_tap_in     = '0;
    bus.in_delay_data_ce    = '0;
    bus.in_delay_data_inc   = '0;
    @(negedge clk);
    #1;

    // Reset held while pins toggle.
    for (int i = 0; i < 3; i++) drive_cycle(13'h1555, 13'h0AAA, 13'h0AAA, 13'h1555);
    check("rst_data",   65'(bus.data_in_to_device), 65'd0);
    check("rst_taps",   65'(bus.in_delay_tap_out),  65'd0);
    check("rst_locked", 65'(bus.delay_locked),      65'd0);

    // Release reset and count edges to lock.
    bus.data_in_from_pins_p = '0;
    bus.data_in_from_pins_n = '0;
    rst_n = 1'b1;
    lock_run("lock");
    zero_cycles(3);
    check("flush0", 65'(bus.data_in_to_device), 65'd0);

    // Tap 0 on lane 5: rise=1, fall=0.
    drive_cycle(L5, '0, '0, L5);
    check("t0_first", 65'(bus.data_in_to_device), 65'd0);
    drive_cycle(L5, '0, '0, L5);
    check("t0_cap1", 65'(bus.data_in_to_device), 65'h20);
    drive_cycle(L5, '0, '0, L5);
    check("t0_cap2", 65'(bus.data_in_to_device), 65'h20);
    zero_cycles(1);
    check("t0_tail", 65'(bus.data_in_to_device), 65'h20);
    zero_cycles(1);
    check("t0_clear", 65'(bus.data_in_to_device), 65'd0);

    // Tap 0 single rise pulse on lane 0.
    drive_cycle(L0, '0, '0, '0);
    check("p0_pre", 65'(bus.data_in_to_device), 65'd0);
    zero_cycles(1);
    check("p0_hit", 65'(bus.data_in_to_device), 65'h1);
    zero_cycles(1);
    check("p0_after", 65'(bus.data_in_to_device), 65'd0);

    // Load tap 1 everywhere, keep the lane 5 pattern running.
    bus.in_delay_reset  = 1'b1;
    bus.in_delay_tap_in = fill_taps(5'd1);
    drive_cycle(L5, '0, '0, L5);
    bus.in_delay_reset  = 1'b0;
    check("t1_taps", 65'(bus.in_delay_tap_out), 65'(fill_taps(5'd1)));
    drive_cycle(L5, '0, '0, L5);
    check("t1_cap1", 65'(bus.data_in_to_device), 65'h40000);
    drive_cycle(L5, '0, '0, L5);
    check("t1_cap2", 65'(bus.data_in_to_device), 65'h40000);

    // Tap 2 on lane 0 only: the pulse lands one cycle later than with tap 0.
    taps                = '0;
    taps[4:0]           = 5'd2;
    bus.in_delay_reset  = 1'b1;
    bus.in_delay_tap_in = taps;
    zero_cycles(1);
    bus.in_delay_reset  = 1'b0;
    check("t2_taps", 65'(bus.in_delay_tap_out), 65'd2);
    zero_cycles(3);
    check("t2_flush", 65'(bus.data_in_to_device), 65'd0);
    drive_cycle(L0, '0, '0, '0);
    zero_cycles(1);
    check("t2_early", 65'(bus.data_in_to_device), 65'd0);
    zero_cycles(1);
    check("t2_hit", 65'(bus.data_in_to_device), 65'h1);
    zero_cycles(1);
    check("t2_after", 65'(bus.data_in_to_device), 65'd0);

    // Step wrap on lane 3.
    taps                = fill_taps(5'd7);
    taps[19:15]         = 5'd31;
    bus.in_delay_reset  = 1'b1;
    bus.in_delay_tap_in = taps;
    zero_cycles(1);
    bus.in_delay_reset  = 1'b0;
    check("wrap_load", 65'(bus.in_delay_tap_out), 65'(taps));
    bus.in_delay_data_ce  = 13'h0008;
    bus.in_delay_data_inc = 13'h0008;
    zero_cycles(1);
    taps[19:15] = 5'd0;
    check("wrap_up", 65'(bus.in_delay_tap_out), 65'(taps));
    bus.in_delay_data_inc = '0;
    zero_cycles(1);
    taps[19:15] = 5'd31;
    check("wrap_down", 65'(bus.in_delay_tap_out), 65'(taps));
    bus.in_delay_data_ce  = '1;
    bus.in_delay_data_inc = '1;
    bus.in_delay_reset    = 1'b1;
    bus.in_delay_tap_in   = fill_taps(5'd9);
    zero_cycles(1);
    bus.in_delay_reset    = 1'b0;
    bus.in_delay_data_ce  = '0;
    bus.in_delay_data_inc = '0;
    check("load_wins", 65'(bus.in_delay_tap_out), 65'(fill_taps(5'd9)));

    // Invalid pair on lane 12 reads 0; a valid pair reads 1.
    for (int i = 0; i < 20; i++) drive_cycle(L12, L12, L12, L12);
    check("inv_pair", 65'(bus.data_in_to_device), 65'd0);
    for (int i = 0; i < 20; i++) drive_cycle(L12, '0, L12, '0);
    check("valid_pair", 65'(bus.data_in_to_device), 65'h2001000);

    // Reset mid-stream clears immediately; lock restarts.
    rst_n = 1'b0;
    #1;
    check("mid_data",   65'(bus.data_in_to_device), 65'd0);
    check("mid_taps",   65'(bus.in_delay_tap_out),  65'd0);
    check("mid_locked", 65'(bus.delay_locked),      65'd0);
    bus.data_in_from_pins_p = '0;
    bus.data_in_from_pins_n = '0;
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    lock_run("relock");
    zero_cycles(1);
    check("post_data", 65'(bus.data_in_to_device), 65'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule : tb_selectio_wiz
